// File: rtl/l2_bus_controller.sv
// l2_bus_controller: round-robin bus arbiter and transaction sequencer in
// front of a shared, direct-mapped L2 array. Serves one core request at a
// time, handles misses through a memory handshake, and writes back dirty
// victims before they are replaced.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; grant the round-robin winner if any req
// LOOKUP  | read L2 at latched addr; hit completes, miss picks a path
// MEM_WB  | write the dirty victim back to memory
// MEM_RD  | fetch the requested line from memory
// INSTALL | write the new line (clean fill or dirty write-back) to L2
// RESP    | one-cycle completion pulse to the granted core
module l2_bus_controller #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 6,
   parameter int INDEX_W   = 4,
   parameter int LINE_W    = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [2*NUM_CORES-1:0]        req_type,
   input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
   input  logic [LINE_W*NUM_CORES-1:0]   req_data,
   output logic [NUM_CORES-1:0]          grant,
   output logic [NUM_CORES-1:0]          resp_valid,
   output logic [LINE_W-1:0]             resp_data,
   output logic                          busy,
   output logic [ADDR_W-1:0]             l2_addr,
   output logic                          l2_valid,
   output logic [2+ADDR_W-INDEX_W+LINE_W-1:0] l2_update,
   input  logic [2+ADDR_W-INDEX_W+LINE_W-1:0] l2_lookup,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [LINE_W-1:0]             mem_wdata,
   input  logic                          mem_ready,
   input  logic [LINE_W-1:0]             mem_rdata,
   output logic [7:0]                    hit_count,
   output logic [7:0]                    miss_count
);

   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int ENT_W = 2 + TAG_W + LINE_W;
   localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_MEM_WB  = 3'd2;
   localparam logic [2:0] S_MEM_RD  = 3'd3;
   localparam logic [2:0] S_INSTALL = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   localparam logic [1:0] BUS_RD   = 2'd0;
   localparam logic [1:0] BUS_RDX  = 2'd1;
   localparam logic [1:0] BUS_UPGR = 2'd2;
   localparam logic [1:0] BUS_WB   = 2'd3;

   localparam logic [1:0] L2_I = 2'd0;
   localparam logic [1:0] L2_C = 2'd1;
   localparam logic [1:0] L2_D = 2'd2;

   logic [2:0]        state_q, state_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [1:0]        type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
   logic [LINE_W-1:0] vic_line_q, vic_line_d;
   logic [7:0]        hit_q, hit_d;
   logic [7:0]        miss_q, miss_d;

   logic              win_found;
   logic [ID_W-1:0]   win_id;

   logic [NUM_CORES-1:0] grant_c;
   logic [NUM_CORES-1:0] resp_valid_c;

   logic [1:0]         lk_state;
   logic [TAG_W-1:0]   lk_tag;
   logic [LINE_W-1:0]  lk_line;
   logic [TAG_W-1:0]   addr_tag;
   logic [INDEX_W-1:0] addr_idx;
   logic               lk_hit;
   logic               is_wb;

   assign lk_state = l2_lookup[ENT_W-1 -: 2];
   assign lk_tag   = l2_lookup[LINE_W +: TAG_W];
   assign lk_line  = l2_lookup[LINE_W-1:0];
   assign addr_tag = addr_q[ADDR_W-1:INDEX_W];
   assign addr_idx = addr_q[INDEX_W-1:0];
   assign lk_hit   = (lk_state != L2_I) && (lk_tag == addr_tag);
   assign is_wb    = (type_q == BUS_WB);

   // Round-robin search: first requester at or after last granted + 1.
   always_comb begin
      logic [ID_W-1:0] cand;
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         cand = ID_W'((int'(last_q) + k) % NUM_CORES);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // Transaction sequencing, L2/memory port drive and counter updates.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      type_d       = type_q;
      addr_d       = addr_q;
      data_d       = data_q;
      line_d       = line_q;
      vic_tag_d    = vic_tag_q;
      vic_line_d   = vic_line_q;
      hit_d        = hit_q;
      miss_d       = miss_q;
      grant_c      = '0;
      resp_valid_c = '0;
      resp_data    = '0;
      l2_addr      = '0;
      l2_valid     = 1'b0;
      l2_update    = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;

      case (state_q)
         S_IDLE: begin
            // Gating with reset_n keeps grant quiet while reset is held.
            if (win_found && reset_n) begin
               grant_c[win_id] = 1'b1;
               id_d   = win_id;
               type_d = req_type[2*win_id +: 2];
               addr_d = req_addr[ADDR_W*win_id +: ADDR_W];
               data_d = req_data[LINE_W*win_id +: LINE_W];
               line_d = '0;
               state_d = (req_type[2*win_id +: 2] == BUS_UPGR) ? S_RESP : S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            l2_addr = addr_q;
            if (lk_hit) begin
               hit_d = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
               if (is_wb) begin
                  l2_valid  = 1'b1;
                  l2_update = {L2_D, addr_tag, data_q};
               end else begin
                  line_d = lk_line;
               end
               state_d = S_RESP;
            end else begin
               miss_d     = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
               vic_tag_d  = lk_tag;
               vic_line_d = lk_line;
               if (lk_state == L2_D)
                  state_d = S_MEM_WB;
               else if (is_wb)
                  state_d = S_INSTALL;
               else
                  state_d = S_MEM_RD;
            end
         end
         S_MEM_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vic_tag_q, addr_idx};
            mem_wdata = vic_line_q;
            if (mem_ready)
               state_d = is_wb ? S_INSTALL : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ready) begin
               line_d  = mem_rdata;
               state_d = S_INSTALL;
            end
         end
         S_INSTALL: begin
            l2_addr  = addr_q;
            l2_valid = 1'b1;
            l2_update = is_wb ? {L2_D, addr_tag, data_q} : {L2_C, addr_tag, line_q};
            state_d  = S_RESP;
         end
         S_RESP: begin
            resp_valid_c[id_q] = 1'b1;
            if (type_q == BUS_RD || type_q == BUS_RDX)
               resp_data = line_q;
            last_d  = id_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign grant      = grant_c;
   assign resp_valid = resp_valid_c;
   assign busy       = (state_q != S_IDLE) || (|grant_c);
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   // State registers; async reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         last_q     <= ID_W'(NUM_CORES - 1);
         id_q       <= '0;
         type_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         line_q     <= '0;
         vic_tag_q  <= '0;
         vic_line_q <= '0;
         hit_q      <= '0;
         miss_q     <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         id_q       <= id_d;
         type_q     <= type_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         line_q     <= line_d;
         vic_tag_q  <= vic_tag_d;
         vic_line_q <= vic_line_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
      end
   end

endmodule

// File: doc/l2_bus_controller.md
Name: l2_bus_controller

Overview:
- Sequencer and arbiter in front of the shared L2 array (16 lines, 2-bit tag, 4-bit index, 1-bit line, states L2_I=0/L2_C=1/L2_D=2).
- Takes bus requests (BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3) from the per-core L1 controllers and grants them round-robin, one transaction at a time.
- Drives L2 array lookups and updates, and handles misses through a memory handshake. Dirty victims are written back before a line is replaced.

Parameters:
- NUM_CORES, 4, number of requesting cores.
- ADDR_W, 6, line address width (8-bit byte address minus 2 offset bits).
- INDEX_W, 4, L2 index width. Tag width TAG_W = ADDR_W-INDEX_W = 2.
- LINE_W, 1, cacheline data width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CORES  per-core request. Held high until that core's grant.
- req_type  in  2*NUM_CORES  bus_req_t per core; core i uses bits [2i+1:2i].
- req_addr  in  ADDR_W*NUM_CORES  line address per core.
- req_data  in  LINE_W*NUM_CORES  write data per core (BUS_WB only).
- grant  out  NUM_CORES  one-hot, 1-cycle pulse.
- resp_valid  out  NUM_CORES  one-hot, 1-cycle completion pulse to the granted core.
- resp_data  out  LINE_W  read data, valid while resp_valid is nonzero.
- busy  out  1  high from grant through resp_valid.
- l2_addr  out  ADDR_W  L2 array address.
- l2_valid  out  1  L2 array write enable.
- l2_update  out  2+TAG_W+LINE_W  {state, tag, line} to write.
- l2_lookup  in  2+TAG_W+LINE_W  {state, tag, line}; combinational read of l2_addr.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write-back, 0 = read.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  write-back data.
- mem_ready  in  1  memory accepts/completes in the cycle mem_req && mem_ready.
- mem_rdata  in  LINE_W  read data, valid when mem_ready && !mem_we.
- hit_count  out  8  saturating L2 hit counter.
- miss_count  out  8  saturating L2 miss counter.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = core 0 highest priority, counters 0.
- Reset mid-transaction aborts immediately: mem_req and l2_valid drop asynchronously, and no response is ever issued for the aborted transaction.
- FSM states: IDLE, LOOKUP, MEM_WB, MEM_RD, INSTALL, RESP.
- IDLE:
  - If any req is high, pulse grant for the winner.
  - Latch the winner's id, type, addr and data; set busy.
  - Winner is the first requesting core at or after (last_granted+1) mod NUM_CORES.
  - Go to LOOKUP, or straight to RESP for BUS_UPGR (no L2 access, resp_data=0, no counter change).
- LOOKUP:
  - l2_addr = latched addr. Hit = state != L2_I && tag == addr[ADDR_W-1:INDEX_W].
  - RD/RDX hit: capture line, hit_count++, go to RESP.
  - WB hit: l2_valid=1 with {L2_D, tag, req_data}, hit_count++, go to RESP.
  - Miss: miss_count++. Victim dirty (L2_D) goes to MEM_WB; otherwise RD/RDX go to MEM_RD and WB goes to INSTALL.
- MEM_WB:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim line. All held stable until mem_ready.
  - Then RD/RDX go to MEM_RD and WB goes to INSTALL.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr = latched addr.
  - On mem_ready, capture mem_rdata and go to INSTALL.
- INSTALL:
  - l2_valid=1. RD/RDX write {L2_C, tag, fetched}; WB writes {L2_D, tag, req_data}.
  - Go to RESP.
- RESP:
  - resp_valid[id]=1; resp_data = captured line (RD/RDX), else 0.
  - Update the round-robin pointer; clear busy; go to IDLE.
  - A new grant may occur in the next cycle.
- Latency from grant: hit = resp_valid 2 cycles after grant; clean miss = 3 cycles + memory wait; dirty miss adds the write-back wait.
- l2_valid is never high outside LOOKUP or INSTALL. mem_req is never high outside MEM_WB or MEM_RD.
- Counters saturate at 255.
- A req dropped before grant is ignored. Requests arriving while busy wait.

Test Plan:
- Reset, then core 2 BUS_RD addr 0x15 with line invalid, memory returns 1 after 2-cycle wait -> mem read addr 0x15, L2[5] = {C, tag 1, 1}, resp_valid=4'b0100, resp_data=1, miss_count=1.
- Repeat that read from core 0 -> hit, no mem_req, resp_data=1 exactly 2 cycles after grant, hit_count=1.
- Core 1 BUS_WB addr 0x25 data 0 while L2[5] = {D, tag 1, 1} -> mem write addr 0x15 data 1, then L2[5] = {D, tag 2, 0}, resp_valid=4'b0010.
- All 4 cores request continuously -> grants in order 0,1,2,3,0 with no core granted twice before the others.
- Core 3 BUS_UPGR -> resp_valid 1 cycle after grant, l2_valid and mem_req stay 0, counters unchanged.
- reset_n low during MEM_RD -> mem_req falls immediately, no resp_valid, next request granted to core 0 first.
